up_counter_mod: RTL and testbench

Synchronous modulo-N up counter. It is the counting-up counterpart to the team's 4-bit down counter and shares its clock/reset interface and count width. Adds a programmable prescaler, parallel load, synchronous clear, wrap/saturate modes, a terminal-count pulse and a sticky overflow flag. It drives timebases and event counters wherever an ascending count is needed.

---
 rtl/counter_pkg.sv | 17 +
 rtl/tick_gen.sv | 30 +++
 rtl/up_counter_mod.sv | 82 ++++++++
 tb/tb_up_counter_mod.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: mode encodings, default width
// and the load-value clamp used by the up counter.
package counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    // Loads beyond the count range land on the top value rather than wrapping.
    function automatic int clamp_load(input int val, input int modulus);
        return (val < modulus) ? val : modulus - 1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits a one-cycle tick every PRESCALE enabled cycles.
// The phase holds while en is low and restarts on sync_clr.
module tick_gen #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);

    localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre;

    assign tick = en && (pre == LAST);

    always_ff @(posedge clk) begin
        if (rst || sync_clr) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else if (en) begin
            pre <= pre + PW'(1);
        end
    end

endmodule

// File: rtl/up_counter_mod.sv
// Modulo-N up counter with prescaler, clamped parallel load, synchronous clear,
// wrap/saturate modes, terminal-count pulse and sticky overflow flag.
module up_counter_mod
    import counter_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int MODULUS  = 16,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sat_mode,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             at_max
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic tick;
    logic step;
    logic sat_hit;
    logic ovf_set;

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sync_clr (clr | load),
        .tick     (tick)
    );

    assign at_max = (count == MAX);
    assign step   = tick && !clr && !load;

    // sat_hit marks that saturation has already been entered, so only the
    // first tick at max in saturate mode raises ovf.
    assign ovf_set = step && at_max && ((sat_mode == MODE_WRAP) || !sat_hit);

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            tc      <= 1'b0;
            ovf     <= 1'b0;
            sat_hit <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (clr) begin
                count   <= '0;
                sat_hit <= 1'b0;
            end else if (load) begin
                count   <= WIDTH'(clamp_load(int'(load_val), MODULUS));
                sat_hit <= 1'b0;
            end else if (step) begin
                if (!at_max) begin
                    count <= count + WIDTH'(1);
                end else if (sat_mode == MODE_WRAP) begin
                    count   <= '0;
                    tc      <= 1'b1;
                    sat_hit <= 1'b0;
                end else begin
                    sat_hit <= 1'b1;
                end
            end

            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_up_counter_mod.sv
// Scoreboard bench: three counter configurations share one stimulus stream;
// a reference model predicts each cycle's outputs and a monitor compares them.
module tb_up_counter_mod;

    localparam int N = 3;
    localparam int MODV[N] = '{16, 5, 10};
    localparam int PREV[N] = '{1, 3, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, clr = 1'b0, load = 1'b0, sat_mode = 1'b0, clr_ovf = 1'b0;
    logic [3:0] load_val = '0;

    logic [3:0] count0, count1, count2;
    logic       tc0, tc1, tc2, ovf0, ovf1, ovf2, am0, am1, am2;

    always #5 clk = ~clk;

    up_counter_mod #(.WIDTH(4), .MODULUS(16), .PRESCALE(1)) u0 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .sat_mode(sat_mode), .clr_ovf(clr_ovf),
        .count(count0), .tc(tc0), .ovf(ovf0), .at_max(am0));
    up_counter_mod #(.WIDTH(4), .MODULUS(5), .PRESCALE(3)) u1 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .sat_mode(sat_mode), .clr_ovf(clr_ovf),
        .count(count1), .tc(tc1), .ovf(ovf1), .at_max(am1));
    up_counter_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u2 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .load_val(load_val),
        .sat_mode(sat_mode), .clr_ovf(clr_ovf),
        .count(count2), .tc(tc2), .ovf(ovf2), .at_max(am2));

    typedef struct {
        int inst;
        int count;
        bit tc;
        bit ovf;
        bit at_max;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: value, enabled cycles since the last step, sticky flag,
    // and whether this instance is already parked at the top in saturate mode.
    int m_count[N];
    int m_phase[N];
    bit m_tc[N];
    bit m_ovf[N];
    bit m_parked[N];

    task automatic model(input int i);
        bit tick;
        bit raise;
        int m;
        m     = MODV[i];
        raise = 1'b0;
        if (rst) begin
            m_count[i] = 0; m_phase[i] = 0; m_tc[i] = 0; m_ovf[i] = 0; m_parked[i] = 0;
            return;
        end
        m_tc[i] = 0;
        if (clr) begin
            m_count[i] = 0; m_phase[i] = 0; m_parked[i] = 0;
        end else if (load) begin
            m_count[i]  = (int'(load_val) < m) ? int'(load_val) : m - 1;
            m_phase[i]  = 0;
            m_parked[i] = 0;
        end else if (en) begin
            tick       = ((m_phase[i] + 1) % PREV[i]) == 0;
            m_phase[i] = (m_phase[i] + 1) % PREV[i];
            if (tick) begin
                if (m_count[i] < m - 1) begin
                    m_count[i] = m_count[i] + 1;
                end else if (!sat_mode) begin
                    m_count[i] = 0; m_tc[i] = 1; raise = 1; m_parked[i] = 0;
                end else if (!m_parked[i]) begin
                    raise = 1; m_parked[i] = 1;
                end
            end
        end
        if (raise)        m_ovf[i] = 1;
        else if (clr_ovf) m_ovf[i] = 0;
    endtask

    task automatic cyc(input bit r, input bit e, input bit c, input bit l,
                       input int lv, input bit s, input bit co);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; clr = c; load = l; load_val = 4'(lv); sat_mode = s; clr_ovf = co;
        for (int i = 0; i < N; i++) begin
            model(i);
            x.inst   = i;
            x.count  = m_count[i];
            x.tc     = m_tc[i];
            x.ovf    = m_ovf[i];
            x.at_max = (m_count[i] == MODV[i] - 1);
            exp_q.push_back(x);
        end
    endtask

    task automatic check(input string name, input int i, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s u%0d @%0t: got %0d, expected %0d", name, i, $time, act, req);
        end
    endtask

    // Monitor: every edge carries one fresh output set per instance.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                case (x.inst)
                    0: begin
                        check("count", 0, int'(count0), x.count);
                        check("tc", 0, int'(tc0), int'(x.tc));
                        check("ovf", 0, int'(ovf0), int'(x.ovf));
                        check("at_max", 0, int'(am0), int'(x.at_max));
                    end
                    1: begin
                        check("count", 1, int'(count1), x.count);
                        check("tc", 1, int'(tc1), int'(x.tc));
                        check("ovf", 1, int'(ovf1), int'(x.ovf));
                        check("at_max", 1, int'(am1), int'(x.at_max));
                    end
                    default: begin
                        check("count", 2, int'(count2), x.count);
                        check("tc", 2, int'(tc2), int'(x.tc));
                        check("ovf", 2, int'(ovf2), int'(x.ovf));
                        check("at_max", 2, int'(am2), int'(x.at_max));
                    end
                endcase
            end
        end
    end

    initial begin
        bit s_rand;
        int waited;

        // Reset, then free-running count through a wrap.
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) cyc(0, 1, 0, 0, 0, 0, 0);

        // Long run with a 4-cycle enable gap mid-period.
        cyc(0, 0, 1, 0, 0, 0, 1);
        for (int k = 0; k < 22; k++) cyc(0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++)  cyc(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 30; k++) cyc(0, 1, 0, 0, 0, 0, 0);

        // Saturate mode: ovf raised once, cleared, and stays clear while parked.
        cyc(0, 0, 1, 0, 0, 1, 1);
        for (int k = 0; k < 25; k++) cyc(0, 1, 0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 1, 1);
        for (int k = 0; k < 10; k++) cyc(0, 1, 0, 0, 0, 1, 0);

        // Load: clamp, wrap from clamped value, in-range load restarts prescaler.
        cyc(0, 0, 0, 1, 12, 0, 1);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 3, 0, 0);
        for (int k = 0; k < 5; k++) cyc(0, 1, 0, 0, 0, 0, 0);

        // Simultaneous events.
        cyc(0, 1, 1, 1, 7, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 15, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 1, 9, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);

        // Reset mid-operation with ovf set.
        cyc(0, 0, 0, 1, 15, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 7, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) cyc(0, 1, 0, 0, 0, 0, 0);

        // Randomized traffic.
        s_rand = 1'b0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 29) == 0) s_rand = ~s_rand;
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0,
                int'($urandom_range(0, 15)), s_rand, $urandom_range(0, 9) == 0);
        end

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
